// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf port buffer: payload default, bus slicing helper
// and the per-channel status record.
package leaf_pkg;

    localparam int PAYLOAD_BITS_DEF = 32;
    localparam int LEVEL_MAX_BITS   = 7;
    localparam int CNT_MAX_BITS     = 64;

    // Widths cover the largest legal DEPTH_BITS and a generous counter.
    typedef struct packed {
        logic [LEVEL_MAX_BITS-1:0] level;
        logic [CNT_MAX_BITS-1:0]   xfer_cnt;
    } chan_status_t;

    function automatic int port_slice(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/leaf_port_fifo.sv
// Single first-word-fall-through channel FIFO with per-channel enable, flush,
// occupancy level and accepted-word counter.
module leaf_port_fifo
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int DEPTH_BITS   = 2,
    parameter int CNT_BITS     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_flush,
    input  logic [PAYLOAD_BITS-1:0] i_wr_data,
    input  logic                    i_wr_vld,
    output logic                    o_wr_ack,
    output logic [PAYLOAD_BITS-1:0] o_rd_data,
    output logic                    o_rd_vld,
    input  logic                    i_rd_ack,
    output logic [DEPTH_BITS:0]     o_level,
    output logic [CNT_BITS-1:0]     o_xfer_cnt
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [DEPTH_BITS-1:0]   r_rd_ptr;
    logic [DEPTH_BITS:0]     r_count;
    logic [CNT_BITS-1:0]     r_xfer_cnt;

    logic w_active;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Reset is folded in so both handshake outputs drop the moment reset asserts.
    assign w_active = rst_n & i_en & ~i_flush;
    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign w_push   = i_wr_vld & ~w_full & w_active;
    assign w_pop    = ~w_empty & w_active & i_rd_ack;

    assign o_wr_ack   = w_push;
    assign o_rd_vld   = ~w_empty & w_active;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_level    = r_count;
    assign o_xfer_cnt = r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_xfer_cnt <= '0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Push and pop together leave the level unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_port_buffer.sv
// Buffered bridge between N HLS ap_hs user ports and the flat leaf_interface buses,
// one FIFO channel per direction and port.
module leaf_port_buffer
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
    parameter int NUM_IN_PORTS  = 4,
    parameter int NUM_OUT_PORTS = 4,
    parameter int DEPTH_BITS    = 2,
    parameter int CNT_BITS      = 32
) (
    input  logic                                           clk_user,
    input  logic                                           reset_n,
    input  logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]          port_en,
    input  logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]          port_flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]           din_user,
    input  logic [NUM_IN_PORTS-1:0]                        vld_user,
    output logic [NUM_IN_PORTS-1:0]                        ack_user,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]           dout_if,
    output logic [NUM_IN_PORTS-1:0]                        vld_if,
    input  logic [NUM_IN_PORTS-1:0]                        ack_if,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]          din_if,
    input  logic [NUM_OUT_PORTS-1:0]                       vld_if_out,
    output logic [NUM_OUT_PORTS-1:0]                       ack_if_out,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]          dout_user,
    output logic [NUM_OUT_PORTS-1:0]                       vld_user_out,
    input  logic [NUM_OUT_PORTS-1:0]                       ack_user_out,
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*(DEPTH_BITS+1)-1:0] level,
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0]       xfer_cnt
);

    localparam int LVL_BITS = DEPTH_BITS + 1;

    // In-port channels occupy status/control indices 0..NUM_IN_PORTS-1.
    for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
        leaf_port_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .DEPTH_BITS   (DEPTH_BITS),
            .CNT_BITS     (CNT_BITS)
        ) u_fifo (
            .clk        (clk_user),
            .rst_n      (reset_n),
            .i_en       (port_en[gi]),
            .i_flush    (port_flush[gi]),
            .i_wr_data  (din_user[port_slice(gi, PAYLOAD_BITS) +: PAYLOAD_BITS]),
            .i_wr_vld   (vld_user[gi]),
            .o_wr_ack   (ack_user[gi]),
            .o_rd_data  (dout_if[port_slice(gi, PAYLOAD_BITS) +: PAYLOAD_BITS]),
            .o_rd_vld   (vld_if[gi]),
            .i_rd_ack   (ack_if[gi]),
            .o_level    (level[port_slice(gi, LVL_BITS) +: LVL_BITS]),
            .o_xfer_cnt (xfer_cnt[port_slice(gi, CNT_BITS) +: CNT_BITS])
        );
    end

    for (genvar go = 0; go < NUM_OUT_PORTS; go++) begin : g_out
        leaf_port_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .DEPTH_BITS   (DEPTH_BITS),
            .CNT_BITS     (CNT_BITS)
        ) u_fifo (
            .clk        (clk_user),
            .rst_n      (reset_n),
            .i_en       (port_en[NUM_IN_PORTS+go]),
            .i_flush    (port_flush[NUM_IN_PORTS+go]),
            .i_wr_data  (din_if[port_slice(go, PAYLOAD_BITS) +: PAYLOAD_BITS]),
            .i_wr_vld   (vld_if_out[go]),
            .o_wr_ack   (ack_if_out[go]),
            .o_rd_data  (dout_user[port_slice(go, PAYLOAD_BITS) +: PAYLOAD_BITS]),
            .o_rd_vld   (vld_user_out[go]),
            .i_rd_ack   (ack_user_out[go]),
            .o_level    (level[port_slice(NUM_IN_PORTS + go, LVL_BITS) +: LVL_BITS]),
            .o_xfer_cnt (xfer_cnt[port_slice(NUM_IN_PORTS + go, CNT_BITS) +: CNT_BITS])
        );
    end

endmodule

// File: tb/tb_leaf_port_buffer.sv
// Scoreboard bench for leaf_port_buffer: directed stimulus pushes expected words into
// per-channel queues and a negedge monitor compares every handshake against them.
module tb_leaf_port_buffer;

    localparam int P   = 32;
    localparam int NI  = 4;
    localparam int NO  = 4;
    localparam int DB  = 2;
    localparam int CB  = 32;
    localparam int NCH = NI + NO;
    localparam int LB  = DB + 1;

    logic              clk_user = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    port_en;
    logic [NCH-1:0]    port_flush;
    logic [NI*P-1:0]   din_user;
    logic [NI-1:0]     vld_user;
    logic [NI-1:0]     ack_user;
    logic [NI*P-1:0]   dout_if;
    logic [NI-1:0]     vld_if;
    logic [NI-1:0]     ack_if;
    logic [NO*P-1:0]   din_if;
    logic [NO-1:0]     vld_if_out;
    logic [NO-1:0]     ack_if_out;
    logic [NO*P-1:0]   dout_user;
    logic [NO-1:0]     vld_user_out;
    logic [NO-1:0]     ack_user_out;
    logic [NCH*LB-1:0] level;
    logic [NCH*CB-1:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;
    int outPops  = 0;
    logic [P-1:0] expIn [NI][$];
    logic [P-1:0] expOut[$];

    leaf_port_buffer #(
        .PAYLOAD_BITS (P),
        .NUM_IN_PORTS (NI),
        .NUM_OUT_PORTS(NO),
        .DEPTH_BITS   (DB),
        .CNT_BITS     (CB)
    ) dut (
        .clk_user     (clk_user),
        .reset_n      (reset_n),
        .port_en      (port_en),
        .port_flush   (port_flush),
        .din_user     (din_user),
        .vld_user     (vld_user),
        .ack_user     (ack_user),
        .dout_if      (dout_if),
        .vld_if       (vld_if),
        .ack_if       (ack_if),
        .din_if       (din_if),
        .vld_if_out   (vld_if_out),
        .ack_if_out   (ack_if_out),
        .dout_user    (dout_user),
        .vld_user_out (vld_user_out),
        .ack_user_out (ack_user_out),
        .level        (level),
        .xfer_cnt     (xfer_cnt)
    );

    always #5 clk_user = ~clk_user;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [P-1:0] data, input logic vld);
        din_user[port*P +: P] = data;
        vld_user[port]        = vld;
    endtask

    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    function automatic logic [LB-1:0] lvlOf(input int ch);
        return level[ch*LB +: LB];
    endfunction

    function automatic logic [CB-1:0] cntOf(input int ch);
        return xfer_cnt[ch*CB +: CB];
    endfunction

    // Inputs settle one time unit after posedge, so the negedge sees the handshake about to commit.
    always @(negedge clk_user) begin
        if (reset_n) begin
            for (int p = 0; p < NI; p++) begin
                if (vld_if[p] && ack_if[p]) begin
                    if (expIn[p].size() == 0)
                        checkOutput($sformatf("in%0d_unexpected_vld", p), vld_if[p], 1'b0);
                    else
                        checkOutput($sformatf("in%0d_data", p), dout_if[p*P +: P], expIn[p].pop_front());
                end
            end
            if (vld_user_out[0] && ack_user_out[0]) begin
                outPops++;
                if (expOut.size() == 0)
                    checkOutput("out0_unexpected_vld", vld_user_out[0], 1'b0);
                else
                    checkOutput("out0_data", dout_user[0 +: P], expOut.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        reset_n      = 1'b0;
        port_en      = '1;
        port_flush   = '0;
        din_user     = '0;
        vld_user     = '0;
        ack_if       = '0;
        din_if       = '0;
        vld_if_out   = '0;
        ack_user_out = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        checkOutput("rst_vld_if", vld_if, '0);
        checkOutput("rst_ack_user", ack_user, '0);
        checkOutput("rst_level", level, '0);
        checkOutput("rst_xfer_cnt", xfer_cnt, '0);

        // Single word through in-port 0.
        applyStimulus(0, 32'hA5A5_0001, 1'b1);
        #1;
        checkOutput("t1_ack_user0", ack_user[0], 1'b1);
        expIn[0].push_back(32'hA5A5_0001);
        tick();
        applyStimulus(0, '0, 1'b0);
        #1;
        checkOutput("t1_vld_if0", vld_if[0], 1'b1);
        checkOutput("t1_level0", lvlOf(0), 1);
        checkOutput("t1_xfer0", cntOf(0), 1);
        ack_if[0] = 1'b1;
        tick();
        ack_if[0] = 1'b0;
        checkOutput("t1_level0_after_pop", lvlOf(0), 0);

        // Fill in-port 1 past capacity.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, P'(i), 1'b1);
            #1;
            checkOutput($sformatf("t2_ack_word%0d", i), ack_user[1], (i <= 4) ? 1'b1 : 1'b0);
            if (i <= 4) expIn[1].push_back(P'(i));
            tick();
        end
        checkOutput("t2_level_full", lvlOf(1), 4);
        checkOutput("t2_xfer_full", cntOf(1), 4);

        // Full with same-cycle pop: push refused, then accepted next cycle.
        ack_if[1] = 1'b1;
        #1;
        checkOutput("t3_ack_when_full_pop", ack_user[1], 1'b0);
        checkOutput("t3_vld_if1", vld_if[1], 1'b1);
        tick();
        ack_if[1] = 1'b0;
        checkOutput("t3_level_after_pop", lvlOf(1), 3);
        #1;
        checkOutput("t3_ack_retry", ack_user[1], 1'b1);
        expIn[1].push_back(32'd5);
        tick();
        applyStimulus(1, '0, 1'b0);
        checkOutput("t3_level_refill", lvlOf(1), 4);
        ack_if[1] = 1'b1;
        budget = 0;
        while (lvlOf(1) != 0 && budget < 20) begin
            tick();
            budget++;
        end
        ack_if[1] = 1'b0;
        checkOutput("t3_drained", lvlOf(1), 0);
        checkOutput("t3_xfer1", cntOf(1), 5);

        // Streaming on out-port 0 (channel NI).
        vld_if_out[0]   = 1'b1;
        ack_user_out[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din_if[0 +: P] = 32'h1000 + P'(i);
            #1;
            checkOutput("t4_ack_if_out0", ack_if_out[0], 1'b1);
            checkOutput("t4_vld_user_out0", vld_user_out[0], (i > 0) ? 1'b1 : 1'b0);
            expOut.push_back(32'h1000 + P'(i));
            tick();
        end
        vld_if_out[0] = 1'b0;
        repeat (2) tick();
        ack_user_out[0] = 1'b0;
        checkOutput("t4_level_out0", lvlOf(NI), 0);
        checkOutput("t4_xfer_out0", cntOf(NI), 100);
        checkOutput("t4_pops_out0", outPops, 100);

        // Disable then flush in-port 2.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 32'h200 + P'(i), 1'b1);
            expIn[2].push_back(32'h200 + P'(i));
            tick();
        end
        checkOutput("t5_level_loaded", lvlOf(2), 3);
        port_en[2] = 1'b0;
        ack_if[2]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("t5_ack_disabled", ack_user[2], 1'b0);
            checkOutput("t5_vld_disabled", vld_if[2], 1'b0);
            tick();
        end
        applyStimulus(2, '0, 1'b0);
        checkOutput("t5_level_held", lvlOf(2), 3);
        port_en[2]    = 1'b1;
        port_flush[2] = 1'b1;
        #1;
        checkOutput("t5_vld_during_flush", vld_if[2], 1'b0);
        tick();
        port_flush[2] = 1'b0;
        expIn[2].delete();
        checkOutput("t5_level_flushed", lvlOf(2), 0);
        checkOutput("t5_xfer_flushed", cntOf(2), 0);
        checkOutput("t5_other_xfer1", cntOf(1), 5);
        checkOutput("t5_other_xfer_out0", cntOf(NI), 100);
        ack_if[2] = 1'b0;

        // Asynchronous reset in the middle of a burst on in-port 0.
        ack_if[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'hB000 + P'(i), 1'b1);
            #1;
            checkOutput("t6_burst_ack", ack_user[0], 1'b1);
            expIn[0].push_back(32'hB000 + P'(i));
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_vld_if", vld_if, '0);
        checkOutput("t6_rst_ack_user", ack_user, '0);
        checkOutput("t6_rst_ack_if_out", ack_if_out, '0);
        checkOutput("t6_rst_vld_user_out", vld_user_out, '0);
        checkOutput("t6_rst_level", level, '0);
        checkOutput("t6_rst_xfer", xfer_cnt, '0);
        for (int p = 0; p < NI; p++) expIn[p].delete();
        applyStimulus(0, '0, 1'b0);
        ack_if[0] = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        applyStimulus(0, 32'h1234, 1'b1);
        #1;
        checkOutput("t6_fresh_ack", ack_user[0], 1'b1);
        expIn[0].push_back(32'h1234);
        tick();
        applyStimulus(0, '0, 1'b0);
        checkOutput("t6_fresh_vld", vld_if[0], 1'b1);
        checkOutput("t6_fresh_data", dout_if[0 +: P], 32'h1234);
        ack_if[0] = 1'b1;
        tick();
        ack_if[0] = 1'b0;
        checkOutput("t6_fresh_level", lvlOf(0), 0);
        checkOutput("t6_fresh_xfer", cntOf(0), 1);

        tick();
        for (int p = 0; p < NI; p++)
            checkOutput($sformatf("end_in%0d_queue_left", p), expIn[p].size(), 0);
        checkOutput("end_out0_queue_left", expOut.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
